pipe_ctrl: RTL

Central pipeline controller for the 5-stage LoongArch core. It merges per-stage stall requests into the shared stall[5:0] vector and sequences exception/ertn redirection: a hold cycle, a one-cycle flush with a new PC, then an optional drain window. It also maintains a stall-cycle performance counter and a stall watchdog. It sits beside the stages and drives the stall/flush inputs of the PC, IF, ID, EX, MEM and WB pipeline registers.

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/pipe_ctrl_stall_watchdog.sv | 34 +++
 rtl/pipe_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM states and the stall
// vector patterns driven onto the PC/IF/ID/EX/MEM/WB registers.
package pipe_ctrl_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_FS   = 6'b000011;
  localparam logic [5:0] STALL_DS   = 6'b000111;
  localparam logic [5:0] STALL_ES   = 6'b001111;
  localparam logic [5:0] STALL_MS   = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  // The deepest requesting stage wins: it freezes itself and everything upstream.
  function automatic logic [5:0] stall_merge(input logic fs, input logic ds,
                                             input logic es, input logic ms);
    if (ms)      return STALL_MS;
    else if (es) return STALL_ES;
    else if (ds) return STALL_DS;
    else if (fs) return STALL_FS;
    else         return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Counts consecutive stalled cycles; raises a sticky timeout once the count
// reaches LIMIT. The counter saturates there until the stall clears.
module stall_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  output logic timeout
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;

  always_comb begin
    cnt_d = '0;
    if (active) cnt_d = (cnt_q == CW'(LIMIT)) ? cnt_q : cnt_q + CW'(1);
    to_d = to_q | (cnt_d == CW'(LIMIT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign timeout = to_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests and sequences
// exception/ertn redirection (hold, one-cycle flush, optional drain).
module pipe_ctrl
  import pipe_ctrl_defs::*;
#(
  parameter int DRAIN_CYCLES = 1,
  parameter int WDOG_LIMIT   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallreq_fs,
  input  logic        stallreq_ds,
  input  logic        stallreq_es,
  input  logic        stallreq_ms,
  input  logic        excp_valid,
  input  logic        ertn_valid,
  input  logic [31:0] excp_target,
  input  logic [31:0] ertn_target,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        new_pc_valid,
  output logic [31:0] stall_cycles,
  output logic        wdog_timeout
);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e        state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [31:0]   new_pc_q, new_pc_d;
  logic [31:0]   stall_cycles_q, stall_cycles_d;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          wdog_active;

  assign redirect    = excp_valid | ertn_valid;
  assign redirect_pc = excp_valid ? excp_target : ertn_target;

  always_comb begin
    state_d        = state_q;
    drain_d        = drain_q;
    new_pc_d       = new_pc_q;
    stall_cycles_d = stall_cycles_q;
    stall          = STALL_NONE;
    flush          = 1'b0;
    new_pc_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          stall    = STALL_ALL;
          new_pc_d = redirect_pc;
          state_d  = FLUSH;
        end else begin
          stall = stall_merge(stallreq_fs, stallreq_ds, stallreq_es, stallreq_ms);
          if (stall[1]) stall_cycles_d = stall_cycles_q + 32'd1;
        end
      end
      FLUSH: begin
        flush        = 1'b1;
        new_pc_valid = 1'b1;
        if (DRAIN_CYCLES > 0) begin
          state_d = DRAIN;
          drain_d = DW'(DRAIN_CYCLES - 1);
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        // A fresh redirect abandons the remaining drain window.
        if (redirect) begin
          stall    = STALL_ALL;
          new_pc_d = redirect_pc;
          state_d  = FLUSH;
        end else begin
          stall = STALL_FS;
          if (drain_q == '0) state_d = IDLE;
          else               drain_d = drain_q - DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      drain_q        <= '0;
      new_pc_q       <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      drain_q        <= drain_d;
      new_pc_q       <= new_pc_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign new_pc       = new_pc_q;
  assign stall_cycles = stall_cycles_q;
  assign wdog_active  = (state_q == IDLE) && (stall != STALL_NONE);

  stall_watchdog #(.LIMIT(WDOG_LIMIT)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .active  (wdog_active),
    .timeout (wdog_timeout)
  );

endmodule
